// File: rtl/wb_register_file.sv
// Write-back select plus 32x32 architectural register file with forwarding taps.
// Optional WB_WRITE_THROUGH_EN: read ports A/B bypass the array on a matching write.
module wb_register_file #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 2**NB_ADDR,
    parameter int RA_REG  = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NB_DATA-1:0] i_output_mem,
    input  logic [NB_DATA-1:0] i_ALU_res,
    input  logic [NB_ADDR-1:0] i_addr_reg_dst,
    input  logic [NB_DATA-1:0] i_pc_to_reg,
    input  logic               is_RegWrite,
    input  logic               is_MemtoReg,
    input  logic               is_select_addr_reg,
    input  logic               is_write_pc,
    input  logic [NB_ADDR-1:0] i_rs_addr,
    input  logic [NB_ADDR-1:0] i_rt_addr,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_debug_data,
    output logic               o_wb_en,
    output logic [NB_ADDR-1:0] o_wb_addr,
    output logic [NB_DATA-1:0] o_wb_data
);

    localparam logic [NB_ADDR-1:0] RA_ADDR = NB_ADDR'(RA_REG);

    logic [NB_DATA-1:0] regs [N_REGS];
    logic [NB_DATA-1:0] rs_arr;
    logic [NB_DATA-1:0] rt_arr;

    always_comb begin
        o_wb_data = i_ALU_res;
        if (is_write_pc)
            o_wb_data = i_pc_to_reg;
        else if (is_MemtoReg)
            o_wb_data = i_output_mem;
    end

    assign o_wb_addr = is_select_addr_reg ? RA_ADDR : i_addr_reg_dst;
    assign o_wb_en   = is_RegWrite && (o_wb_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++)
                regs[i] <= '0;
        end else if (o_wb_en) begin
            regs[o_wb_addr] <= o_wb_data;
        end
    end

    // r0 is hard-wired to zero regardless of array contents
    assign rs_arr       = (i_rs_addr == '0) ? '0 : regs[i_rs_addr];
    assign rt_arr       = (i_rt_addr == '0) ? '0 : regs[i_rt_addr];
    assign o_debug_data = (i_debug_addr == '0) ? '0 : regs[i_debug_addr];

`ifdef WB_WRITE_THROUGH_EN
    // o_wb_en already excludes r0, so address 0 is never bypassed
    assign o_rs_data = (o_wb_en && i_rs_addr == o_wb_addr) ? o_wb_data : rs_arr;
    assign o_rt_data = (o_wb_en && i_rt_addr == o_wb_addr) ? o_wb_data : rt_arr;
`else
    assign o_rs_data = rs_arr;
    assign o_rt_data = rt_arr;
`endif

endmodule
